// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states,
// access-size decoding and legality check.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        WAIT0,
        ISSUE1,
        WAIT1,
        DONE
    } lsu_state_e;

    // Unshifted byte mask for the access size: 1, 2 or 4 bytes.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        logic [3:0] m;
        case (lsu_funct3_e'(funct3))
            LSU_B, LSU_BU: m = 4'b0001;
            LSU_H, LSU_HU: m = 4'b0011;
            default:       m = 4'b1111;
        endcase
        return m;
    endfunction

    // Unsigned variants only make sense for loads.
    function automatic logic funct3_legal(input logic [2:0] funct3, input logic we);
        logic ok;
        case (lsu_funct3_e'(funct3))
            LSU_B, LSU_H, LSU_W: ok = 1'b1;
            LSU_BU, LSU_HU:      ok = !we;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-organized data-memory bus with per-byte enables; the LSU is the master.
interface lsu_if;
    import lsu_pkg::*;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte-enable masks for both word accesses,
// store-data shifting into lanes, and load-data extraction with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_lo,
    input  logic [31:0] rd_hi,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic        split,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] rdata
);

    logic [7:0]  mask;
    logic [63:0] lane_mask;
    logic [63:0] wshift;
    logic [31:0] rshift;
    logic [4:0]  shamt;

    assign shamt = {offset, 3'b000};
    assign mask  = {4'b0000, size_mask(funct3)} << offset;
    assign be0   = mask[3:0];
    assign be1   = mask[7:4];
    assign split = |mask[7:4];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{mask[gi]}};
        end
    endgenerate

    // Lanes outside the access are forced to zero so stray upper store bits never reach memory.
    assign wshift = ({32'd0, wdata} << shamt) & lane_mask;
    assign wdata0 = wshift[31:0];
    assign wdata1 = wshift[63:32];

    assign rshift = 32'({rd_hi, rd_lo} >> shamt);

    always_comb begin
        rdata = rshift;
        case (lsu_funct3_e'(funct3))
            LSU_B:   rdata = {{24{rshift[7]}}, rshift[7:0]};
            LSU_H:   rdata = {{16{rshift[15]}}, rshift[15:0]};
            LSU_BU:  rdata = {24'd0, rshift[7:0]};
            LSU_HU:  rdata = {16'd0, rshift[15:0]};
            default: rdata = rshift;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core request, issues one or two
// word transactions on the memory bus and returns merged, extended load data.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [31:0] lsu_rdata,
    lsu_if.master       mem
);

    lsu_state_e  state_reg, state_next;
    logic        we_reg, we_next;
    logic [2:0]  funct3_reg, funct3_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        err_reg, err_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] rdata_reg, rdata_next;

    logic [3:0]  be0, be1;
    logic        split;
    logic [31:0] wdata0, wdata1;
    logic [31:0] rd_lo, rd_hi;
    logic [31:0] ld_rdata;
    logic [31:0] addr0, addr1;

    // The word arriving this cycle is merged directly so the result is ready with done.
    assign rd_lo = (state_reg == WAIT0) ? mem.rdata : lo_reg;
    assign rd_hi = (state_reg == WAIT1) ? mem.rdata : 32'd0;

    lsu_align u_align (
        .funct3 (funct3_reg),
        .offset (addr_reg[1:0]),
        .wdata  (wdata_reg),
        .rd_lo  (rd_lo),
        .rd_hi  (rd_hi),
        .be0    (be0),
        .be1    (be1),
        .split  (split),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .rdata  (ld_rdata)
    );

    assign addr0 = {addr_reg[31:2], 2'b00};
    assign addr1 = addr0 + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= 32'd0;
            wdata_reg  <= 32'd0;
            err_reg    <= 1'b0;
            lo_reg     <= 32'd0;
            rdata_reg  <= 32'd0;
        end else begin
            state_reg  <= state_next;
            we_reg     <= we_next;
            funct3_reg <= funct3_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            err_reg    <= err_next;
            lo_reg     <= lo_next;
            rdata_reg  <= rdata_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        we_next     = we_reg;
        funct3_next = funct3_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        err_next    = err_reg;
        lo_next     = lo_reg;
        rdata_next  = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (lsu_req) begin
                    we_next     = lsu_we;
                    funct3_next = lsu_funct3;
                    addr_next   = lsu_addr;
                    wdata_next  = lsu_wdata;
                    err_next    = !funct3_legal(lsu_funct3, lsu_we);
                    state_next  = funct3_legal(lsu_funct3, lsu_we) ? ISSUE0 : DONE;
                end
            end
            ISSUE0: begin
                if (mem.ready) begin
                    if (!we_reg)    state_next = WAIT0;
                    else if (split) state_next = ISSUE1;
                    else            state_next = DONE;
                end
            end
            WAIT0: begin
                if (mem.rvalid) begin
                    lo_next = mem.rdata;
                    if (split) begin
                        state_next = ISSUE1;
                    end else begin
                        rdata_next = ld_rdata;
                        state_next = DONE;
                    end
                end
            end
            ISSUE1: begin
                if (mem.ready) state_next = we_reg ? DONE : WAIT1;
            end
            WAIT1: begin
                if (mem.rvalid) begin
                    rdata_next = ld_rdata;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs decode from state and latched request only; idle bus drives zeros.
    assign mem.req   = (state_reg == ISSUE0) || (state_reg == ISSUE1);
    assign mem.we    = mem.req && we_reg;
    assign mem.addr  = (state_reg == ISSUE0) ? addr0 :
                       (state_reg == ISSUE1) ? addr1 : 32'd0;
    assign mem.be    = (state_reg == ISSUE0) ? be0 :
                       (state_reg == ISSUE1) ? be1 : 4'b0000;
    assign mem.wdata = !mem.we               ? 32'd0  :
                       (state_reg == ISSUE0) ? wdata0 : wdata1;

    assign lsu_busy  = (state_reg != IDLE) && (state_reg != DONE);
    assign lsu_done  = (state_reg == DONE);
    assign lsu_err   = (state_reg == DONE) && err_reg;
    assign lsu_rdata = rdata_reg;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit that sits between the RV32I core datapath and a word-organized data memory with per-byte write enables. It is the initiator side of the data-memory access protocol. It converts one core load/store request (address, funct3 size/sign, store data) into one or two word-aligned memory transactions, splitting misaligned accesses across a word boundary. It then merges and sign/zero-extends read data back to the core with a done pulse.

## Interface
- No parameters; address and data are fixed at 32 bits.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- lsu_req  in  1  core request strobe; sampled only when lsu_busy=0
- lsu_we  in  1  1=store, 0=load
- lsu_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- lsu_addr  in  32  byte address, any alignment
- lsu_wdata  in  32  store data, right-justified
- lsu_busy  out  1  high from the cycle after an accepted request until lsu_done
- lsu_done  out  1  one-cycle completion pulse
- lsu_err  out  1  valid with lsu_done; 1 = illegal funct3 (also illegal store codes 100/101)
- lsu_rdata  out  32  extended load result, valid with lsu_done, held until next done
- m_req  out  1  memory transaction request, held until m_ready
- m_we  out  1  write transaction
- m_addr  out  32  word-aligned address (bits[1:0]=00)
- m_be  out  4  byte enables (bit i = byte lane i)
- m_wdata  out  32  lane-aligned write data
- m_ready  in  1  memory accepts the transaction this cycle when m_req & m_ready
- m_rvalid  in  1  read data valid (≥1 cycle after read acceptance, in order)
- m_rdata  in  32  read word

## Operation
- Size: B/BU=1, H/HU=2, W=4 bytes; o=lsu_addr[1:0].
- 8-bit mask M = ((1<<size)-1) << o; access0 be=M[3:0] at {addr[31:2],00}; access1 needed iff M[7:4]≠0, be=M[7:4] at access0 addr+4 (mod 2^32, 0xFFFFFFFC wraps to 0x00000000).
- Store data: 64-bit W = lsu_wdata << 8*o; access0 uses W[31:0], access1 W[63:32]. Disabled lanes drive 0.
- Load: capture lo word (access0) and hi word (access1, else 0) into 64-bit buffer; result = buffer >> 8*o, truncated to size, sign-extended for B/H, zero-extended for BU/HU, W unextended.
- Illegal funct3: no memory transaction, lsu_err=1 with done, lsu_rdata unchanged.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE.
  - IDLE: lsu_req → latch all inputs, go ISSUE0 (or DONE with err if illegal).
  - ISSUE0: m_req=1; on m_ready: store → ISSUE1 if split else DONE; load → WAIT0.
  - WAIT0: on m_rvalid capture lo; → ISSUE1 if split else DONE.
  - ISSUE1/WAIT1: same for access1; → DONE.
  - DONE: lsu_done=1, lsu_busy=0 → IDLE.
- lsu_req while busy: ignored (not queued). m_rvalid in IDLE/ISSUE*/DONE: ignored.
- Reset mid-operation: immediate return to IDLE, outstanding transaction abandoned, late m_rvalid ignored.

## Timing
- Reset values: m_req, m_we, m_be, lsu_busy, lsu_done, lsu_err = 0; m_addr, m_wdata, lsu_rdata = 0.
- All outputs registered or decoded from state/latched registers only; no combinational path core→memory.
- Request accepted in cycle 0; m_req asserted in cycle 1.
- Zero-wait memory: aligned store done in cycle 2; split store in cycle 3; aligned load (rvalid 1 cycle after accept) done in cycle 3; split load in cycle 5.
- Each m_ready wait state adds one cycle; m_req, m_addr, m_be, m_wdata stable while m_req & !m_ready.
- Illegal funct3: done/err in cycle 1.
- Back-to-back: next lsu_req accepted in the cycle after done (IDLE).

## Structure
- lsu_pkg: funct3 enum (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU), FSM state enum, size decode function.
- Sub-module lsu_align (combinational): mask/byte-enable generation, 64-bit store shift, load shift and extension. lsu_ctrl holds the FSM and registers.

## Test plan
- SW 0xDEADBEEF @0x100, zero-wait → one write, m_addr=0x100, be=1111, wdata=0xDEADBEEF, done cycle 2.
- LB @0x103, memory word 0x80FF_0000 → one read, be=1000, lsu_rdata=0xFFFFFF80; LBU same → 0x00000080.
- LW @0x102, words 0x11223344 @0x100 and 0x55667788 @0x104 → two reads, be 1100 then 0011, lsu_rdata=0x77881122, done cycle 5.
- SH 0xABCD @0x0FFF_FFFF… use @0xFFFFFFFF → writes be=1000 @0xFFFFFFFC wdata=0xCD000000, then be=0001 @0x00000000 wdata=0x000000AB.
- m_ready low 3 cycles during ISSUE0 → outputs stable, done delayed 3 cycles; lsu_req pulsed while busy ignored.
- funct3=011 → no m_req, done+err cycle 1; rst_n low in WAIT0 → all outputs 0, late m_rvalid no effect, next request normal.
